ddr_frame_reader: RTL and testbench

DDR_FRAME_READER -- requirements
Module: ddr_frame_reader

---
 rtl/ddr_frame_reader_pkg.sv | 25 ++
 rtl/vb_sync2ff.sv | 23 ++
 rtl/ddr_frame_reader.sv | 184 ++++++++++++++++++
 tb/tb_ddr_frame_reader.sv | 422 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_frame_reader_pkg.sv
// Shared definitions for the DDR frame reader.
// Holds the FSM state encoding, line pitch, reset frame base, start
// delay and the beats-per-line helper used when a frame is latched.
package ddr_frame_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_AR_REQ   = 2'd1,
        ST_READING  = 2'd2,
        ST_LINE_CHK = 2'd3
    } state_t;

    localparam logic [23:0] LINE_GAP         = 24'h00_2000;
    localparam logic [7:0]  RESET_START_ADDR = 8'h78;
    localparam int          START_DELAY      = 5;
    localparam int          MAX_BEATS        = 256;

    // One beat carries 16 pixels; a line never exceeds one 256-beat burst.
    function automatic logic [8:0] calc_beats(input logic [15:0] hres);
        logic [15:0] per_line;
        per_line = hres >> 4;
        return (per_line > 16'(MAX_BEATS)) ? 9'(MAX_BEATS) : per_line[8:0];
    endfunction

endpackage

// File: rtl/vb_sync2ff.sv
// Two-flop synchronizer for a single slow-changing level.
// Ports: aclk/aresetn destination clock and async active-low reset,
//        d asynchronous input, q synchronized output.
module vb_sync2ff (
    input  logic aclk,
    input  logic aresetn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ddr_frame_reader.sv
// Reads one video frame from DDR over AXI, one burst per line, and streams
// the returned beats to a pixel sink with zero latency.
// Ports: aclk/aresetn clock and async active-low reset; enable_i,
//        frame_swap_i (toggle per frame request), frame_start_addr_i,
//        horiz/vert_resolution_i frame setup; AR* and R* AXI read channels;
//        pix_* stream to the sink with sof_o/eol_o qualifiers;
//        frame_done_o completion pulse; len_err_o sticky burst-length error.
//
// state       | meaning
// ST_IDLE     | waiting for a frame start (or a pending one)
// ST_AR_REQ   | presenting the line's read address until accepted
// ST_READING  | passing burst beats to the sink until RLAST
// ST_LINE_CHK | deciding between next line and end of frame
module ddr_frame_reader
    import ddr_frame_reader_pkg::*;
#(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int FRAME_ADDR_LENGTH = 8,
    parameter int AXI_DATA_WIDTH    = 512
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         enable_i,
    input  logic                         frame_swap_i,
    input  logic [FRAME_ADDR_LENGTH-1:0] frame_start_addr_i,
    input  logic [15:0]                  horiz_resolution_i,
    input  logic [15:0]                  vert_resolution_i,
    input  logic                         ARREADY,
    output logic                         ARVALID,
    output logic [ADDRESS_WIDTH-1:0]     ARADDR,
    output logic [7:0]                   ARLEN,
    input  logic [AXI_DATA_WIDTH-1:0]    RDATA,
    input  logic                         RVALID,
    input  logic                         RLAST,
    output logic                         RREADY,
    output logic [AXI_DATA_WIDTH-1:0]    pix_data_o,
    output logic                         pix_valid_o,
    input  logic                         pix_ready_i,
    output logic                         sof_o,
    output logic                         eol_o,
    output logic                         frame_done_o,
    output logic                         len_err_o
);

    state_t                       state, state_nx;
    logic                         swap_sync, swap_prev, swap_edge;
    logic [START_DELAY-1:0]       edge_dly;
    logic                         start, pending, go;
    logic [FRAME_ADDR_LENGTH-1:0] start_addr;
    logic [8:0]                   beats, beats_in, beat_cnt;
    logic [7:0]                   arlen;
    logic [23:0]                  line_off;
    logic [15:0]                  line_cnt;
    logic                         xfer, last_beat, more_lines;
    logic                         latch_frame, next_line, end_frame, done_nx;

    vb_sync2ff u_swap_sync (
        .aclk    (aclk),
        .aresetn (aresetn),
        .d       (frame_swap_i),
        .q       (swap_sync)
    );

    assign swap_edge  = swap_sync ^ swap_prev;
    assign start      = edge_dly[START_DELAY-1] & enable_i;
    assign go         = start | pending;
    assign beats_in   = calc_beats(horiz_resolution_i);
    assign xfer       = (state == ST_READING) & RVALID & pix_ready_i;
    assign last_beat  = (beat_cnt == beats - 9'd1);
    assign more_lines = ({1'b0, line_cnt} + 17'd1) < {1'b0, vert_resolution_i};

    assign ARADDR      = ADDRESS_WIDTH'({start_addr, line_off});
    assign ARLEN       = arlen;
    assign pix_data_o  = RDATA;
    assign pix_valid_o = (state == ST_READING) & RVALID;
    assign sof_o       = pix_valid_o & (line_cnt == 16'd0) & (beat_cnt == 9'd0);
    assign eol_o       = pix_valid_o & last_beat;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            swap_prev <= 1'b0;
            edge_dly  <= '0;
            pending   <= 1'b0;
        end else begin
            swap_prev <= swap_sync;
            edge_dly  <= {edge_dly[START_DELAY-2:0], swap_edge};
            // IDLE always consumes a start; elsewhere keep one, drop extras.
            if (state == ST_IDLE) begin
                pending <= 1'b0;
            end else if (start) begin
                pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        latch_frame = 1'b0;
        next_line   = 1'b0;
        end_frame   = 1'b0;
        done_nx     = 1'b0;
        ARVALID     = 1'b0;
        RREADY      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (go) begin
                    latch_frame = 1'b1;
                    if ((beats_in != 9'd0) && (vert_resolution_i != 16'd0)) begin
                        state_nx = ST_AR_REQ;
                    end else begin
                        done_nx = 1'b1;
                    end
                end
            end
            ST_AR_REQ: begin
                ARVALID = 1'b1;
                if (ARREADY) begin
                    state_nx = ST_READING;
                end
            end
            ST_READING: begin
                RREADY = pix_ready_i;
                if (xfer && RLAST) begin
                    state_nx = ST_LINE_CHK;
                end
            end
            ST_LINE_CHK: begin
                if (more_lines && enable_i) begin
                    next_line = 1'b1;
                    state_nx  = ST_AR_REQ;
                end else begin
                    end_frame = 1'b1;
                    done_nx   = !more_lines;
                    state_nx  = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            start_addr   <= FRAME_ADDR_LENGTH'(RESET_START_ADDR);
            beats        <= '0;
            arlen        <= '0;
            line_off     <= '0;
            line_cnt     <= '0;
            beat_cnt     <= '0;
            frame_done_o <= 1'b0;
            len_err_o    <= 1'b0;
        end else begin
            if (latch_frame) begin
                start_addr <= frame_start_addr_i;
                beats      <= beats_in;
                arlen      <= 8'(beats_in - 9'd1);
                line_off   <= '0;
                line_cnt   <= '0;
            end else if (next_line) begin
                line_off <= line_off + LINE_GAP;
                line_cnt <= line_cnt + 16'd1;
            end else if (end_frame) begin
                line_off <= '0;
                line_cnt <= '0;
            end
            if (xfer) begin
                beat_cnt <= RLAST ? 9'd0 : beat_cnt + 9'd1;
            end
            // RLAST and the expected last beat must coincide exactly.
            if (xfer && (RLAST != last_beat)) begin
                len_err_o <= 1'b1;
            end
            frame_done_o <= done_nx;
        end
    end

endmodule

// File: tb/tb_ddr_frame_reader.sv
module tb_ddr_frame_reader;

    localparam int AW = 32;
    localparam int FW = 8;
    localparam int DW = 512;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          enable_i;
    logic          frame_swap_i;
    logic [FW-1:0] frame_start_addr_i;
    logic [15:0]   horiz_resolution_i;
    logic [15:0]   vert_resolution_i;
    logic          ARREADY;
    logic          ARVALID;
    logic [AW-1:0] ARADDR;
    logic [7:0]    ARLEN;
    logic [DW-1:0] RDATA;
    logic          RVALID;
    logic          RLAST;
    logic          RREADY;
    logic [DW-1:0] pix_data_o;
    logic          pix_valid_o;
    logic          pix_ready_i;
    logic          sof_o;
    logic          eol_o;
    logic          frame_done_o;
    logic          len_err_o;

    always #5 aclk = ~aclk;

    ddr_frame_reader #(
        .ADDRESS_WIDTH     (AW),
        .FRAME_ADDR_LENGTH (FW),
        .AXI_DATA_WIDTH    (DW)
    ) dut (
        .aclk               (aclk),
        .aresetn            (aresetn),
        .enable_i           (enable_i),
        .frame_swap_i       (frame_swap_i),
        .frame_start_addr_i (frame_start_addr_i),
        .horiz_resolution_i (horiz_resolution_i),
        .vert_resolution_i  (vert_resolution_i),
        .ARREADY            (ARREADY),
        .ARVALID            (ARVALID),
        .ARADDR             (ARADDR),
        .ARLEN              (ARLEN),
        .RDATA              (RDATA),
        .RVALID             (RVALID),
        .RLAST              (RLAST),
        .RREADY             (RREADY),
        .pix_data_o         (pix_data_o),
        .pix_valid_o        (pix_valid_o),
        .pix_ready_i        (pix_ready_i),
        .sof_o              (sof_o),
        .eol_o              (eol_o),
        .frame_done_o       (frame_done_o),
        .len_err_o          (len_err_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
        int          beats;
    } ar_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          sof;
        logic          eol;
    } px_t;

    ar_t         exp_ar[$];
    px_t         exp_px[$];
    logic [31:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    int          done_at_ar[$];

    int n_checks = 0;
    int n_pass   = 0;
    int ar_cnt   = 0;
    int xfer_cnt = 0;
    int eol_cnt  = 0;
    int done_cnt = 0;

    logic        exp_len_err  = 1'b0;
    logic        prev_done    = 1'b0;
    bit          mon_en       = 1'b0;
    bit          slave_active = 1'b0;
    int          cur_beat     = 0;
    int          cur_len      = 0;
    int          cur_beats    = 0;
    logic [31:0] cur_addr     = '0;
    int          early_len    = 0;
    bit          pr_tog       = 1'b0;
    bit          ar_tog       = 1'b0;
    bit          noise        = 1'b0;
    logic        pr_level     = 1'b1;

    function automatic logic [DW-1:0] data_of(input logic [31:0] a, input int b);
        logic [31:0] w;
        w = a + 32'(b) * 32'h9E37_79B9;
        return {16{w}};
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Expected AR and pixel streams from frame geometry alone.
    task automatic plan_frame(input logic [7:0] base, input int hres, input int vres, input int lines);
        int          beats;
        logic [31:0] addr;
        px_t         p;
        ar_t         a;
        beats = hres / 16;
        if (beats > 256) beats = 256;
        if (beats == 0 || vres == 0) return;
        for (int l = 0; l < lines; l++) begin
            addr   = {base, 24'(l * 32'h2000)};
            a.addr = addr;
            a.len  = 8'(beats - 1);
            a.beats = beats;
            exp_ar.push_back(a);
            for (int b = 0; b < beats; b++) begin
                p.d   = data_of(addr, b);
                p.sof = (l == 0) && (b == 0);
                p.eol = (b == beats - 1);
                exp_px.push_back(p);
            end
        end
    endtask

    task automatic kick(input logic [7:0] base, input int hres, input int vres);
        frame_start_addr_i = base;
        horiz_resolution_i = 16'(hres);
        vert_resolution_i  = 16'(vres);
        frame_swap_i       = ~frame_swap_i;
    endtask

    task automatic clear_counts();
        ar_cnt   = 0;
        xfer_cnt = 0;
        eol_cnt  = 0;
        done_cnt = 0;
        ar_addr_log.delete();
        ar_len_log.delete();
        done_at_ar.delete();
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_done(input int target, input string name);
        int n = 0;
        while (done_cnt < target && n < 2000) begin
            step(1);
            n++;
        end
        if (done_cnt < target) fail_now(name);
        step(4);
    endtask

    task automatic wait_ar(input int target, input string name);
        int n = 0;
        while (ar_cnt < target && n < 500) begin
            step(1);
            n++;
        end
        if (ar_cnt < target) fail_now(name);
    endtask

    task automatic chk_empty(input string name);
        chk({name, "_ar_left"}, exp_ar.size(), 0);
        chk({name, "_px_left"}, exp_px.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_arvalid"}, ARVALID, 0);
        chk({name, "_araddr"}, ARADDR, 32'h7800_0000);
        chk({name, "_arlen"}, ARLEN, 0);
        chk({name, "_rready"}, RREADY, 0);
        chk({name, "_pix_valid"}, pix_valid_o, 0);
        chk({name, "_sof"}, sof_o, 0);
        chk({name, "_eol"}, eol_o, 0);
        chk({name, "_frame_done"}, frame_done_o, 0);
        chk({name, "_len_err"}, len_err_o, 0);
    endtask

    // Monitor, scoreboard and AXI read slave.
    initial begin
        ar_t h;
        forever begin
            @(negedge aclk);
            if (mon_en) begin
                chk("rready", RREADY, slave_active && pix_ready_i);
                chk("pix_valid", pix_valid_o, slave_active && RVALID);
                chk("len_err", len_err_o, exp_len_err);
                if (frame_done_o) begin
                    chk("done_pulse_prev", prev_done, 0);
                    done_cnt++;
                end
                prev_done = frame_done_o;
                if (pix_valid_o) begin
                    if (exp_px.size() == 0) begin
                        fail_now("unexpected_beat");
                    end else begin
                        chk("pix_data", pix_data_o, exp_px[0].d);
                        chk("sof", sof_o, exp_px[0].sof);
                        chk("eol", eol_o, exp_px[0].eol);
                    end
                end else begin
                    chk("sof_idle", sof_o, 0);
                    chk("eol_idle", eol_o, 0);
                end
                if (RVALID && RREADY && slave_active) begin
                    if (exp_px.size() > 0) void'(exp_px.pop_front());
                    xfer_cnt++;
                    if (eol_o) eol_cnt++;
                    if (RLAST) begin
                        slave_active = 1'b0;
                        if (cur_beat != cur_beats - 1) exp_len_err = 1'b1;
                    end
                    cur_beat++;
                end
                if (ARVALID) begin
                    chk("one_outstanding", slave_active, 0);
                    if (exp_ar.size() == 0) begin
                        fail_now("unexpected_ar");
                    end else begin
                        chk("araddr", ARADDR, exp_ar[0].addr);
                        chk("arlen", ARLEN, exp_ar[0].len);
                        if (ARREADY) begin
                            h = exp_ar.pop_front();
                            ar_addr_log.push_back(ARADDR);
                            ar_len_log.push_back(ARLEN);
                            done_at_ar.push_back(done_cnt);
                            ar_cnt++;
                            slave_active = 1'b1;
                            cur_addr     = ARADDR;
                            cur_beat     = 0;
                            cur_len      = (early_len != 0) ? early_len : int'(ARLEN) + 1;
                            cur_beats    = h.beats;
                        end
                    end
                end
            end
            @(posedge aclk);
            #1;
            ARREADY     = ar_tog ? ~ARREADY : 1'b1;
            pix_ready_i = pr_tog ? ~pix_ready_i : pr_level;
            if (slave_active) begin
                RVALID = 1'b1;
                RDATA  = data_of(cur_addr, cur_beat);
                RLAST  = (cur_beat == cur_len - 1);
            end else begin
                RVALID = noise;
                RDATA  = noise ? {16{32'hDEAD_BEEF}} : '0;
                RLAST  = noise;
            end
        end
    end

    initial begin
        px_t p;
        ar_t a;
        aresetn            = 1'b0;
        enable_i           = 1'b1;
        frame_swap_i       = 1'b0;
        frame_start_addr_i = '0;
        horiz_resolution_i = '0;
        vert_resolution_i  = '0;
        ARREADY            = 1'b1;
        RDATA              = '0;
        RVALID             = 1'b0;
        RLAST              = 1'b0;
        pix_ready_i        = 1'b1;
        step(3);
        chk_reset_outputs("reset");
        aresetn = 1'b1;
        mon_en  = 1'b1;
        step(3);

        // Three lines of four beats at base 0x10.
        clear_counts();
        plan_frame(8'h10, 64, 3, 3);
        kick(8'h10, 64, 3);
        wait_done(1, "t1_done");
        chk_empty("t1");
        chk("t1_ar_cnt", ar_cnt, 3);
        if (ar_cnt == 3) begin
            chk("t1_addr0", ar_addr_log[0], 32'h1000_0000);
            chk("t1_addr1", ar_addr_log[1], 32'h1000_2000);
            chk("t1_addr2", ar_addr_log[2], 32'h1000_4000);
            chk("t1_len0", ar_len_log[0], 3);
        end
        chk("t1_beats", xfer_cnt, 12);
        chk("t1_eol", eol_cnt, 3);
        chk("t1_done_cnt", done_cnt, 1);

        // Full 256-beat line, then a line that must be clamped to 256.
        clear_counts();
        plan_frame(8'h22, 4096, 1, 1);
        kick(8'h22, 4096, 1);
        wait_done(1, "t2_done");
        chk_empty("t2");
        chk("t2_ar_cnt", ar_cnt, 1);
        if (ar_cnt == 1) chk("t2_len", ar_len_log[0], 255);
        chk("t2_beats", xfer_cnt, 256);

        clear_counts();
        plan_frame(8'h23, 8192, 1, 1);
        kick(8'h23, 8192, 1);
        wait_done(1, "t3_done");
        chk_empty("t3");
        if (ar_cnt == 1) chk("t3_len", ar_len_log[0], 255);
        chk("t3_beats", xfer_cnt, 256);

        // Degenerate geometry: no bursts, done pulse only.
        clear_counts();
        kick(8'h24, 8, 2);
        wait_done(1, "t4a_done");
        chk("t4a_ar_cnt", ar_cnt, 0);
        chk("t4a_done_cnt", done_cnt, 1);
        clear_counts();
        kick(8'h25, 64, 0);
        wait_done(1, "t4b_done");
        chk("t4b_ar_cnt", ar_cnt, 0);

        // Sink and ARREADY toggling, noise on RVALID outside bursts.
        clear_counts();
        pr_tog = 1'b1;
        ar_tog = 1'b1;
        noise  = 1'b1;
        plan_frame(8'h55, 48, 2, 2);
        kick(8'h55, 48, 2);
        wait_done(1, "t5_done");
        pr_tog = 1'b0;
        ar_tog = 1'b0;
        noise  = 1'b0;
        step(3);
        chk_empty("t5");
        chk("t5_beats", xfer_cnt, 6);
        chk("t5_eol", eol_cnt, 2);

        // RLAST on beat 2 of 4.
        clear_counts();
        early_len = 2;
        a.addr  = 32'h6600_0000;
        a.len   = 8'd3;
        a.beats = 4;
        exp_ar.push_back(a);
        p.d = data_of(32'h6600_0000, 0); p.sof = 1'b1; p.eol = 1'b0; exp_px.push_back(p);
        p.d = data_of(32'h6600_0000, 1); p.sof = 1'b0; p.eol = 1'b0; exp_px.push_back(p);
        kick(8'h66, 64, 1);
        wait_done(1, "t6_done");
        early_len = 0;
        chk_empty("t6");
        chk("t6_beats", xfer_cnt, 2);
        chk("t6_len_err", len_err_o, 1);

        // Second request mid-frame waits for the first frame to finish.
        clear_counts();
        plan_frame(8'h20, 64, 3, 3);
        plan_frame(8'h20, 64, 3, 3);
        kick(8'h20, 64, 3);
        wait_ar(1, "t7_first_ar");
        frame_swap_i = ~frame_swap_i;
        wait_done(2, "t7_done");
        chk_empty("t7");
        chk("t7_ar_cnt", ar_cnt, 6);
        chk("t7_beats", xfer_cnt, 24);
        if (ar_cnt == 6) begin
            chk("t7_done_before_ar2", done_at_ar[2], 0);
            chk("t7_done_before_ar3", done_at_ar[3], 1);
        end

        // enable_i dropped during line 1 of 3.
        clear_counts();
        plan_frame(8'h30, 64, 3, 2);
        kick(8'h30, 64, 3);
        wait_ar(2, "t8_second_ar");
        enable_i = 1'b0;
        step(20);
        chk_empty("t8");
        chk("t8_ar_cnt", ar_cnt, 2);
        chk("t8_beats", xfer_cnt, 8);
        chk("t8_done_cnt", done_cnt, 0);
        enable_i = 1'b1;
        step(2);

        // Reset while a beat is stalled on the bus.
        clear_counts();
        pr_level = 1'b0;
        plan_frame(8'h40, 64, 1, 1);
        kick(8'h40, 64, 1);
        wait_ar(1, "t9_ar");
        step(2);
        mon_en = 1'b0;
        @(negedge aclk);
        chk("t9_valid_before_reset", pix_valid_o, 1);
        chk("t9_len_err_before_reset", len_err_o, 1);
        aresetn = 1'b0;
        #1;
        chk_reset_outputs("t9_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
